// File: rtl/pipeline_controller.sv
// Pipeline controller: selects one pipeline action per cycle (advance, stall, flush,
// drain, halt), tracks stall/flush statistics and raises a sticky stall watchdog.
//
// Parameters:
//   STALL_LIMIT   consecutive data-stall cycles that set stall_timeout
//   DRAIN_CYCLES  drain cycles between HLT acceptance and halt (must be >= 1)
//
// Ports:
//   clk            clock, all state updates on rising edge
//   rst            asynchronous active-high reset
//   data_hazard    RAW hazard on the ID instruction
//   control_hazard CALL/RET/B in flight
//   redirect       EX/MEM loading a new PC
//   halt_req       HLT decoded in ID
//   pc_en          PC write enable
//   if_id_en       IF/ID write enable
//   if_id_flush    load NOP into IF/ID
//   id_ex_bubble   load NOP into ID/EX
//   halted         core halted
//   stall_timeout  sticky watchdog flag
//   stall_cnt      saturating count of data-stall cycles
//   flush_cnt      saturating count of flush cycles
module pipeline_controller #(
    parameter int unsigned STALL_LIMIT  = 8,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_hazard,
    input  logic        control_hazard,
    input  logic        redirect,
    input  logic        halt_req,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        halted,
    output logic        stall_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam int unsigned ConsecW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam int unsigned DrainW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [ConsecW-1:0] ConsecMax = ConsecW'(STALL_LIMIT);
    localparam logic [DrainW-1:0]  DrainInit = DrainW'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalted
    } state_e;

    state_e              state_q, state_d;
    logic [DrainW-1:0]   drain_q, drain_d;
    logic [ConsecW-1:0]  consec_q, consec_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;
    logic [15:0]         flush_cnt_q, flush_cnt_d;
    logic                timeout_q, timeout_d;

    logic                is_stall;
    logic                is_flush;

    // Next-state and pipeline control; the reset-state outputs are the defaults so an
    // asserted rst forces them combinationally regardless of clk.
    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        is_stall     = 1'b0;
        is_flush     = 1'b0;

        if (!rst) begin
            unique case (state_q)
                StRun: begin
                    if (redirect) begin
                        pc_en        = 1'b1;
                        if_id_en     = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        is_flush     = 1'b1;
                    end else if (control_hazard) begin
                        // ID instruction advances, nothing new fetched
                        pc_en        = 1'b0;
                        if_id_en     = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b0;
                        is_flush     = 1'b1;
                    end else if (data_hazard) begin
                        // hold ID, bubble into EX
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        if_id_flush  = 1'b0;
                        id_ex_bubble = 1'b1;
                        is_stall     = 1'b1;
                    end else if (halt_req) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b0;
                        is_flush     = 1'b1;
                        drain_d      = DrainInit;
                        state_d      = StDrain;
                    end else begin
                        pc_en        = 1'b1;
                        if_id_en     = 1'b1;
                        if_id_flush  = 1'b0;
                        id_ex_bubble = 1'b0;
                    end
                end

                StDrain: begin
                    is_flush = 1'b1;
                    if (redirect) begin
                        pc_en        = 1'b1;
                        if_id_en     = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_d      = StRun;
                    end else begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        drain_d      = drain_q - DrainW'(1);
                        // counter at 1 means this is the last drain cycle
                        if (drain_q <= DrainW'(1)) begin
                            state_d = StHalted;
                        end
                    end
                end

                StHalted: begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end

                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    // Statistics and watchdog next-state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        consec_d    = '0;

        if (is_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (is_flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
        if (is_stall) begin
            consec_d = (consec_q == ConsecMax) ? consec_q : consec_q + ConsecW'(1);
        end

        timeout_d = timeout_q | (consec_d == ConsecMax);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            drain_q     <= '0;
            consec_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            consec_q    <= consec_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign halted        = (state_q == StHalted);
    assign stall_timeout = timeout_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
module tb_pipeline_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_hazard = 1'b0;
    logic        control_hazard = 1'b0;
    logic        redirect = 1'b0;
    logic        halt_req = 1'b0;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        halted;
    logic        stall_timeout;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic [3:0]  ctl;
    int          checks = 0;
    int          errors = 0;

    // {pc_en, if_id_en, if_id_flush, id_ex_bubble}
    assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_bubble};

    pipeline_controller #(
        .STALL_LIMIT (8),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_hazard   (data_hazard),
        .control_hazard(control_hazard),
        .redirect      (redirect),
        .halt_req      (halt_req),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .halted        (halted),
        .stall_timeout (stall_timeout),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        data_hazard    = 1'b0;
        control_hazard = 1'b0;
        redirect       = 1'b0;
        halt_req       = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (ctl !== 4'b0011) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected %b", ctl, 4'b0011);
        end
        checks++;
        if ({halted, stall_timeout, stall_cnt, flush_cnt} !== 34'd0) begin
            errors++;
            $display("FAIL reset_state: got halted=%b to=%b sc=%h fc=%h expected all 0",
                     halted, stall_timeout, stall_cnt, flush_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release_normal: got %b expected %b", ctl, 4'b1100);
        end
    endtask

    task automatic test_data_stall();
        do_reset();
        data_hazard = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== 4'b0001) begin
                errors++;
                $display("FAIL stall_ctl[%0d]: got %b expected %b", i, ctl, 4'b0001);
            end
            step();
        end
        data_hazard = 1'b0;
        #1;
        checks++;
        if ({stall_cnt, flush_cnt, stall_timeout} !== {16'd3, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL stall_counts: got sc=%0d fc=%0d to=%b expected sc=3 fc=0 to=0",
                     stall_cnt, flush_cnt, stall_timeout);
        end
        checks++;
        if (ctl !== 4'b1100) begin
            errors++;
            $display("FAIL stall_resume: got %b expected %b", ctl, 4'b1100);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        data_hazard = 1'b1;
        repeat (7) step();
        checks++;
        if (stall_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got %b expected 0", stall_timeout);
        end
        step();
        checks++;
        if ({stall_timeout, ctl} !== {1'b1, 4'b0001}) begin
            errors++;
            $display("FAIL timeout_set: got to=%b ctl=%b expected to=1 ctl=0001",
                     stall_timeout, ctl);
        end
        data_hazard = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b1100) begin
            errors++;
            $display("FAIL timeout_ctl_normal: got %b expected %b", ctl, 4'b1100);
        end
        step();
        step();
        checks++;
        if ({stall_timeout, stall_cnt} !== {1'b1, 16'd8}) begin
            errors++;
            $display("FAIL timeout_sticky: got to=%b sc=%0d expected to=1 sc=8",
                     stall_timeout, stall_cnt);
        end
        // Broken runs of 7 must not trip the watchdog.
        do_reset();
        data_hazard = 1'b1;
        repeat (7) step();
        data_hazard = 1'b0;
        step();
        data_hazard = 1'b1;
        repeat (7) step();
        data_hazard = 1'b0;
        checks++;
        if ({stall_timeout, stall_cnt} !== {1'b0, 16'd14}) begin
            errors++;
            $display("FAIL timeout_nonconsec: got to=%b sc=%0d expected to=0 sc=14",
                     stall_timeout, stall_cnt);
        end
    endtask

    task automatic test_priority();
        do_reset();
        redirect = 1'b1;
        control_hazard = 1'b1;
        data_hazard = 1'b1;
        #1;
        checks++;
        if (ctl !== 4'b1111) begin
            errors++;
            $display("FAIL prio_redirect_ctl: got %b expected %b", ctl, 4'b1111);
        end
        step();
        checks++;
        if ({flush_cnt, stall_cnt} !== {16'd1, 16'd0}) begin
            errors++;
            $display("FAIL prio_redirect_cnt: got fc=%0d sc=%0d expected fc=1 sc=0",
                     flush_cnt, stall_cnt);
        end
        redirect = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b0110) begin
            errors++;
            $display("FAIL prio_control_ctl: got %b expected %b", ctl, 4'b0110);
        end
        step();
        control_hazard = 1'b0;
        halt_req = 1'b1;
        #1;
        checks++;
        if (ctl !== 4'b0001) begin
            errors++;
            $display("FAIL prio_data_over_halt: got %b expected %b", ctl, 4'b0001);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if ({ctl, flush_cnt, stall_cnt} !== {4'b1100, 16'd2, 16'd1}) begin
            errors++;
            $display("FAIL prio_after: got ctl=%b fc=%0d sc=%0d expected ctl=1100 fc=2 sc=1",
                     ctl, flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_halt();
        do_reset();
        halt_req = 1'b1;
        #1;
        checks++;
        if ({ctl, halted} !== {4'b0110, 1'b0}) begin
            errors++;
            $display("FAIL halt_accept: got ctl=%b h=%b expected ctl=0110 h=0", ctl, halted);
        end
        step();
        halt_req = 1'b0;
        data_hazard = 1'b1;
        control_hazard = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({ctl, halted} !== {4'b0111, 1'b0}) begin
                errors++;
                $display("FAIL halt_drain[%0d]: got ctl=%b h=%b expected ctl=0111 h=0",
                         i, ctl, halted);
            end
            step();
        end
        clear_inputs();
        #1;
        checks++;
        if ({halted, ctl, flush_cnt, stall_cnt} !== {1'b1, 4'b0011, 16'd4, 16'd0}) begin
            errors++;
            $display("FAIL halt_reached: got h=%b ctl=%b fc=%0d sc=%0d expected h=1 ctl=0011 fc=4 sc=0",
                     halted, ctl, flush_cnt, stall_cnt);
        end
        redirect = 1'b1;
        data_hazard = 1'b1;
        repeat (2) begin
            #1;
            checks++;
            if ({halted, ctl} !== {1'b1, 4'b0011}) begin
                errors++;
                $display("FAIL halt_ignore: got h=%b ctl=%b expected h=1 ctl=0011", halted, ctl);
            end
            step();
        end
        checks++;
        if ({halted, flush_cnt, stall_cnt} !== {1'b1, 16'd4, 16'd0}) begin
            errors++;
            $display("FAIL halt_no_count: got h=%b fc=%0d sc=%0d expected h=1 fc=4 sc=0",
                     halted, flush_cnt, stall_cnt);
        end
        // Asynchronous exit from HALTED.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({halted, ctl, flush_cnt} !== {1'b0, 4'b0011, 16'd0}) begin
            errors++;
            $display("FAIL halt_async_reset: got h=%b ctl=%b fc=%0d expected h=0 ctl=0011 fc=0",
                     halted, ctl, flush_cnt);
        end
        clear_inputs();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b1100) begin
            errors++;
            $display("FAIL halt_reset_release: got %b expected %b", ctl, 4'b1100);
        end
    endtask

    task automatic test_drain_redirect();
        do_reset();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        step();
        redirect = 1'b1;
        #1;
        checks++;
        if ({ctl, halted} !== {4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL drain_redirect_ctl: got ctl=%b h=%b expected ctl=1111 h=0", ctl, halted);
        end
        step();
        redirect = 1'b0;
        #1;
        checks++;
        if ({ctl, flush_cnt} !== {4'b1100, 16'd3}) begin
            errors++;
            $display("FAIL drain_redirect_run: got ctl=%b fc=%0d expected ctl=1100 fc=3",
                     ctl, flush_cnt);
        end
        repeat (4) step();
        checks++;
        if ({halted, ctl} !== {1'b0, 4'b1100}) begin
            errors++;
            $display("FAIL drain_redirect_stay: got h=%b ctl=%b expected h=0 ctl=1100",
                     halted, ctl);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ctl, flush_cnt} !== {4'b0011, 16'd0}) begin
            errors++;
            $display("FAIL drain_async_reset: got ctl=%b fc=%0d expected ctl=0011 fc=0",
                     ctl, flush_cnt);
        end
        step();
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({halted, ctl, flush_cnt} !== {1'b0, 4'b1100, 16'd0}) begin
            errors++;
            $display("FAIL drain_reset_run: got h=%b ctl=%b fc=%0d expected h=0 ctl=1100 fc=0",
                     halted, ctl, flush_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        data_hazard = 1'b1;
        repeat (65537) step();
        checks++;
        if ({stall_cnt, stall_timeout} !== {16'hFFFF, 1'b1}) begin
            errors++;
            $display("FAIL sat_stall_cnt: got sc=%h to=%b expected sc=ffff to=1",
                     stall_cnt, stall_timeout);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({stall_cnt, flush_cnt, stall_timeout, halted} !== 34'd0) begin
            errors++;
            $display("FAIL sat_async_clear: got sc=%h fc=%h to=%b h=%b expected all 0",
                     stall_cnt, flush_cnt, stall_timeout, halted);
        end
        clear_inputs();
        step();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_data_stall();
        test_timeout();
        test_priority();
        test_halt();
        test_drain_redirect();
        test_reset_mid_drain();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
